// File: rtl/bitserial_acc_ctrl_pkg.sv
// Shared types and sizing for the bit-serial shift-accumulate sequencer.
package bitserial_acc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_PSUM_W  = 12;
  localparam int DEF_IN_BITS = 8;

  // One guard bit on top of psum width plus plane growth keeps signed*signed exact.
  function automatic int calc_acc_w(input int psum_w, input int in_bits);
    return psum_w + in_bits + 1;
  endfunction

endpackage

// File: rtl/bitserial_acc_ctrl_add.sv
// Generic W-bit adder with carry-in; sus selects signed extension of the carry-out bit.
module add #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sus,
  output logic [W:0]   sum
);

  logic [W:0] ax, bx;

  assign ax  = {sus & a[W-1], a};
  assign bx  = {sus & b[W-1], b};
  assign sum = ax + bx + {{W{1'b0}}, cin};

endmodule

// File: rtl/bitserial_acc_ctrl.sv
// Bit-serial MAC sequencer: shift-accumulates one partial sum per activation plane, MSB first.
module bitserial_acc_ctrl
  import bitserial_acc_ctrl_pkg::*;
#(
  parameter int PSUM_W  = DEF_PSUM_W,
  parameter int IN_BITS = DEF_IN_BITS,
  parameter int ACC_W   = calc_acc_w(PSUM_W, IN_BITS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_signed,
  input  logic              psum_signed,
  output logic              busy,
  input  logic              psum_valid,
  output logic              psum_ready,
  input  logic [PSUM_W-1:0] psum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data
);

  localparam int CNT_W = $clog2(IN_BITS);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(IN_BITS - 1);

  state_e           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             in_sgn, ps_sgn;

  logic             hs, neg;
  logic [ACC_W-1:0] pe, opa, opb, acc_next;
  logic [ACC_W:0]   sum;

  assign psum_ready = (state == ACC);
  assign hs         = psum_valid & psum_ready;

  assign pe  = {{(ACC_W-PSUM_W){ps_sgn & psum[PSUM_W-1]}}, psum};
  // MSB activation plane carries negative weight in signed mode: subtract as ~pe + 1.
  assign neg = in_sgn & (cnt == CNT_TOP);
  assign opa = {acc[ACC_W-2:0], 1'b0};
  assign opb = neg ? ~pe : pe;

  add #(.W(ACC_W)) u_add (
    .a   (opa),
    .b   (opb),
    .cin (neg),
    .sus (1'b1),
    .sum (sum)
  );

  assign acc_next = sum[ACC_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      in_sgn    <= 1'b0;
      ps_sgn    <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            in_sgn <= in_signed;
            ps_sgn <= psum_signed;
            cnt    <= CNT_TOP;
            acc    <= '0;
            busy   <= 1'b1;
            state  <= ACC;
          end
        end
        ACC: begin
          if (hs) begin
            acc <= acc_next;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
              out_data  <= acc_next;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitserial_acc_ctrl.sv
// Directed bench for bitserial_acc_ctrl with hand-computed expected results.
module tb_bitserial_acc_ctrl;

  localparam int PSUM_W = 12;
  localparam int IN_BITS = 8;
  localparam int ACC_W = 21;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_signed = 1'b0;
  logic              psum_signed = 1'b0;
  logic              busy;
  logic              psum_valid = 1'b0;
  logic              psum_ready;
  logic [PSUM_W-1:0] psum = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ACC_W-1:0]  out_data;

  int tests = 0;
  int fails = 0;
  int hs_cnt;

  bitserial_acc_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_signed   (in_signed),
    .psum_signed (psum_signed),
    .busy        (busy),
    .psum_valid  (psum_valid),
    .psum_ready  (psum_ready),
    .psum        (psum),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic is, input logic ps);
    start = 1'b1;
    in_signed = is;
    psum_signed = ps;
    step();
    start = 1'b0;
    in_signed = 1'b0;
    psum_signed = 1'b0;
  endtask

  // One plane with `gap` idle cycles before it; counts the handshake it makes.
  task automatic feed(input logic [PSUM_W-1:0] v, input int gap);
    psum_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      if (psum_ready && psum_valid) hs_cnt++;
      step();
    end
    psum = v;
    psum_valid = 1'b1;
    if (psum_ready) hs_cnt++;
    step();
    psum_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic is, input logic ps,
                        input logic [PSUM_W-1:0] v_msb, input logic [PSUM_W-1:0] v_rest,
                        input int gap, input logic [ACC_W-1:0] exp);
    do_start(is, ps);
    chk({tag, "_busy"}, ACC_W'(busy), 1);
    chk({tag, "_rdy"}, ACC_W'(psum_ready), 1);
    hs_cnt = 0;
    for (int i = 0; i < IN_BITS; i++) begin
      if (i == IN_BITS - 1) chk({tag, "_vld_early"}, ACC_W'(out_valid), 0);
      feed((i == 0) ? v_msb : v_rest, gap);
    end
    chk({tag, "_vld"}, ACC_W'(out_valid), 1);
    chk({tag, "_data"}, out_data, exp);
    chk({tag, "_rdy_after"}, ACC_W'(psum_ready), 0);
    chk({tag, "_hs"}, ACC_W'(hs_cnt), ACC_W'(IN_BITS));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_vld_clr"}, ACC_W'(out_valid), 0);
    chk({tag, "_idle"}, ACC_W'(busy), 0);
    chk({tag, "_hold"}, out_data, exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    chk("rst_busy", ACC_W'(busy), 0);
    chk("rst_rdy", ACC_W'(psum_ready), 0);
    chk("rst_vld", ACC_W'(out_valid), 0);
    chk("rst_data", out_data, 0);
    step();
    rst = 1'b0;
    step();

    run_op("uns_ones", 1'b0, 1'b0, 12'd1, 12'd1, 0, 21'd255);
    run_op("in_sgn", 1'b1, 1'b0, 12'd10, 12'd0, 0, 21'h1FFB00);
    run_op("ps_sgn", 1'b0, 1'b1, 12'hFFF, 12'hFFF, 0, 21'h1FFF01);
    run_op("both_sgn", 1'b1, 1'b1, 12'hFFF, 12'hFFF, 0, 21'd1);
    run_op("max_uns", 1'b0, 1'b0, 12'd4095, 12'd4095, 0, 21'd1044225);
    run_op("max_gap", 1'b0, 1'b0, 12'd4095, 12'd4095, 3, 21'd1044225);

    // Stray start and mode flips during ACC, then backpressure with start held in DONE.
    do_start(1'b0, 1'b0);
    hs_cnt = 0;
    for (int i = 0; i < IN_BITS; i++) begin
      start = (i == 3);
      in_signed = (i == 3);
      psum_signed = (i == 3);
      feed(12'd3, 0);
    end
    chk("bp_vld", ACC_W'(out_valid), 1);
    chk("bp_hs", ACC_W'(hs_cnt), ACC_W'(IN_BITS));
    for (int c = 0; c < 5; c++) begin
      start = 1'b1;
      in_signed = 1'b1;
      step();
      chk("bp_vld_hold", ACC_W'(out_valid), 1);
      chk("bp_data_hold", out_data, 21'd765);
    end
    out_ready = 1'b1;
    start = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_vld_clr", ACC_W'(out_valid), 0);
    chk("bp_start_on_exit", ACC_W'(busy), 0);
    start = 1'b0;
    in_signed = 1'b0;
    step();
    chk("bp_still_idle", ACC_W'(busy), 0);
    chk("bp_no_second", ACC_W'(out_valid), 0);
    chk("bp_data_kept", out_data, 21'd765);

    // Abort mid-ACC by asynchronous reset.
    do_start(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) feed(12'd5, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", ACC_W'(busy), 0);
    chk("abort_rdy", ACC_W'(psum_ready), 0);
    chk("abort_vld", ACC_W'(out_valid), 0);
    chk("abort_data", out_data, 0);
    step();
    rst = 1'b0;
    step();
    chk("abort_stays_idle", ACC_W'(out_valid), 0);
    run_op("after_abort", 1'b0, 1'b0, 12'd2, 12'd2, 0, 21'd510);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bitserial_acc_ctrl.md
Name: bitserial_acc_ctrl

Overview:
Sequencer for the macro's signed/unsigned adder in bit-serial MAC mode. Input activations are applied one bit-plane per step, MSB first. The array returns one PSUM_W-bit partial sum per plane, and this block shift-accumulates those partial sums into the final dot-product result. It sits between the CIM column partial-sum output and the macro's result interface, and owns one adder instance plus the plane counter and handshakes.

Parameters:
PSUM_W, 12, width of each incoming partial sum
IN_BITS, 8, activation bit-planes per operation (>=2)
ACC_W, PSUM_W+IN_BITS+1, accumulator/result width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  begin an operation; accepted only in IDLE
in_signed  in  1  activations are two's complement (MSB plane carries weight -2^(IN_BITS-1)); sampled on start
psum_signed  in  1  partial sums are two's complement, else unsigned; sampled on start
busy  out  1  high in ACC and DONE
psum_valid  in  1  partial sum present
psum_ready  out  1  block accepts a partial sum
psum  in  PSUM_W  partial sum for current plane
out_valid  out  1  result valid
out_ready  in  1  result consumer ready
out_data  out  ACC_W  two's-complement result

Behaviour:
- Reset (async, any state): state=IDLE; acc=0; plane count=0; captured modes=0; busy=0, psum_ready=0, out_valid=0, out_data=0.
- States:
  - IDLE -> ACC on start. Captures in_signed/psum_signed, sets count=IN_BITS-1 and acc=0.
  - ACC -> DONE on the handshake where count==0.
  - DONE -> IDLE on out_valid&out_ready.
- psum_ready = (state==ACC), combinational from state only.
- Partial-sum acceptance:
  - A plane is accepted on psum_valid&psum_ready.
  - Gaps are allowed; acc and count hold while psum_valid=0.
  - psum_valid is ignored outside ACC.
- Extension: psum is zero- or sign-extended to ACC_W per the captured psum_signed, giving pe.
- Update per accepted plane: acc_next = (acc<<1) + term.
  - term = -pe if in_signed captured and the plane is the first (MSB) plane.
  - Otherwise term = pe.
  - Negation is ~pe+1 fed to the adder with carry-in logic or an equivalent subtract.
  - All arithmetic is modulo 2^ACC_W; the default ACC_W cannot overflow for any input combination.
- count decrements on each accepted plane.
- Result timing:
  - out_data is registered and loaded with acc_next on the final handshake.
  - out_valid rises the cycle after the final handshake (latency 1).
  - out_valid and out_data hold stable until out_ready is sampled high.
  - out_data retains its last value afterwards; out_valid clears.
- Adder use: a single adder instance, one addition per accepted plane, no pipelining.
- start outside IDLE is ignored: no restart, and the mode inputs are not recaptured.
- start in the same cycle as the DONE->IDLE transition is ignored; start is only accepted while in IDLE.
- A mode change on in_signed/psum_signed mid-operation has no effect.
- Reset asserted mid-ACC or mid-DONE aborts immediately. No result is emitted, and the next operation starts clean.

Decomposition:
- Shared package holds:
  - state enum (IDLE, ACC, DONE)
  - localparam for default PSUM_W/IN_BITS
  - function computing ACC_W from PSUM_W and IN_BITS
- One sub-module: the existing `add` adder, instantiated at width ACC_W with sus tied high. Operands are already extended, and its sum MSB is dropped.
- Counter, FSM and extension/negation logic stay in this block.

Test Plan:
- Unsigned both: start, 8 planes of psum=1 -> out_data=255, out_valid one cycle after the 8th handshake, psum_ready low after.
- in_signed=1, psum_signed=0: MSB plane psum=10, other planes 0 -> out_data=-1280 (21'h1FFB00).
- psum_signed=1, all planes psum=12'hFFF: with in_signed=0 -> -255; with in_signed=1 -> +1.
- Max unsigned: all planes psum=4095, both modes 0 -> 1044225. psum_valid toggled with 3-cycle gaps gives the same result and the same handshake count.
- Backpressure and stray start: hold out_ready=0 for 5 cycles in DONE -> out_valid/out_data stable; start pulsed during ACC and DONE is ignored (exactly 8 handshakes, a single result).
- Reset mid-op: assert rst after the 4th plane -> all outputs 0 asynchronously. A new unsigned run of psum=2 ×8 then gives 510.
